regfile_2w_sb: RTL and testbench

Parametrised two-read, two-write register file with an integrated busy-bit scoreboard for the decode stage of the five-stage pipeline. It takes write-back from two independent ports, such as the ALU result and the second operand of a SWAP or load. Same-cycle write data is forwarded to the read ports. Decode uses the per-register busy bits to detect RAW hazards before issuing.

---
 rtl/regfile_2w_sb.sv | 118 +++++++++++
 tb/tb_regfile_2w_sb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w_sb.sv
// Two-read, two-write register file with a per-register busy scoreboard for decode-stage RAW detection.
// Optional feature macro: REGFILE_BYPASS_EN (forwards same-cycle write data and masks busy on landing write-back).
module regfile_2w_sb #(
   parameter int W = 16,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we0,
   input  logic [N-1:0] wa0,
   input  logic [W-1:0] wd0,
   input  logic         we1,
   input  logic [N-1:0] wa1,
   input  logic [W-1:0] wd1,
   input  logic [N-1:0] src,
   input  logic [N-1:0] dst,
   output logic [W-1:0] rsrc,
   output logic [W-1:0] rdst,
   input  logic         rsv_en,
   input  logic [N-1:0] rsv_addr,
   output logic         src_busy,
   output logic         dst_busy,
   output logic         any_busy
);

   localparam int DEPTH = 1 << N;

   logic [W-1:0]     r_mem [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_set;
   logic [DEPTH-1:0] w_clr;
   logic [W-1:0]     w_rsrc;
   logic [W-1:0]     w_rdst;
   logic             w_src_busy;
   logic             w_dst_busy;

   // Per-register reserve and write-back decode
   always_comb begin
      w_set = {DEPTH{1'b0}};
      w_clr = {DEPTH{1'b0}};
      for (int r = 0; r < DEPTH; r++) begin
         w_set[r] = rsv_en && (rsv_addr == N'(r));
         w_clr[r] = (we0 && (wa0 == N'(r))) || (we1 && (wa1 == N'(r)));
      end
   end

   // Storage update; port 1 is assigned last so it wins an address collision
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_mem[r] <= {W{1'b0}};
         end
      end else begin
         if (we0) begin
            r_mem[wa0] <= wd0;
         end
         if (we1) begin
            r_mem[wa1] <= wd1;
         end
      end
   end

   // Busy bits: a new reservation overrides a coinciding write-back clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= {DEPTH{1'b0}};
      end else begin
         r_busy <= w_set | (r_busy & ~w_clr);
      end
   end

   // Read port A data select
   always_comb begin
      w_rsrc = r_mem[src];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (wa1 == src)) begin
         w_rsrc = wd1;
      end else if (we0 && (wa0 == src)) begin
         w_rsrc = wd0;
      end else begin
         w_rsrc = r_mem[src];
      end
`endif
   end

   // Read port B data select
   always_comb begin
      w_rdst = r_mem[dst];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (wa1 == dst)) begin
         w_rdst = wd1;
      end else if (we0 && (wa0 == dst)) begin
         w_rdst = wd0;
      end else begin
         w_rdst = r_mem[dst];
      end
`endif
   end

   // Busy lookup; with forwarding, a landing write-back means the operand is already available
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      w_src_busy = r_busy[src] & ~w_clr[src];
      w_dst_busy = r_busy[dst] & ~w_clr[dst];
`else
      w_src_busy = r_busy[src];
      w_dst_busy = r_busy[dst];
`endif
   end

   // Forwarded data must not leak through while reset is held
   assign rsrc     = rst ? w_rsrc : {W{1'b0}};
   assign rdst     = rst ? w_rdst : {W{1'b0}};
   assign src_busy = rst & w_src_busy;
   assign dst_busy = rst & w_dst_busy;
   assign any_busy = rst & (|r_busy);

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Randomized and directed bench for regfile_2w_sb against an array-based reference model.
module tb_regfile_2w_sb;

   localparam int W = 16;
   localparam int N = 3;
   localparam int D = 8;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         we0, we1, rsv_en;
   logic [N-1:0] wa0, wa1, src, dst, rsv_addr;
   logic [W-1:0] wd0, wd1, rsrc, rdst;
   logic         src_busy, dst_busy, any_busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] m_mem [D];
   bit           m_busy [D];

   regfile_2w_sb #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .src(src), .dst(dst), .rsrc(rsrc), .rdst(rdst),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .src_busy(src_busy), .dst_busy(dst_busy), .any_busy(any_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_rd(input logic [N-1:0] a);
      if (BYP && we1 && (wa1 == a)) return wd1;
      if (BYP && we0 && (wa0 == a)) return wd0;
      return m_mem[a];
   endfunction

   function automatic bit exp_busy(input logic [N-1:0] a);
      bit landing;
      landing = (we0 && (wa0 == a)) || (we1 && (wa1 == a));
      return m_busy[a] && !(BYP && landing);
   endfunction

   function automatic bit exp_any();
      bit any;
      any = 1'b0;
      foreach (m_busy[i]) any = any | m_busy[i];
      return any;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Apply one rising edge to the model: writes in port order, clears before the reservation
   task automatic model_edge();
      if (we0) m_mem[wa0] = wd0;
      if (we1) m_mem[wa1] = wd1;
      if (we0) m_busy[wa0] = 1'b0;
      if (we1) m_busy[wa1] = 1'b0;
      if (rsv_en) m_busy[rsv_addr] = 1'b1;
   endtask

   task automatic idle();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      src = '0; dst = '0;
   endtask

   // Inputs are set 1 time unit after a rising edge; compare mid-cycle, then advance
   task automatic cycle(input string tag);
      #4;
      check({tag, ".rsrc"}, 32'(rsrc), 32'(exp_rd(src)));
      check({tag, ".rdst"}, 32'(rdst), 32'(exp_rd(dst)));
      check({tag, ".src_busy"}, 32'(src_busy), 32'(exp_busy(src)));
      check({tag, ".dst_busy"}, 32'(dst_busy), 32'(exp_busy(dst)));
      check({tag, ".any_busy"}, 32'(any_busy), 32'(exp_any()));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      #1 rst = 1'b0;
      #2;
      check("rst_hold.rsrc", 32'(rsrc), 32'h0);
      check("rst_hold.any", 32'(any_busy), 32'h0);
      #9 rst = 1'b1;
      @(posedge clk);
      #1;

      // Dual write
      we0 = 1'b1; wa0 = 3'd2; wd0 = 16'h00AA;
      we1 = 1'b1; wa1 = 3'd5; wd1 = 16'h5500;
      cycle("dual_w");
      idle(); src = 3'd2; dst = 3'd5;
      #3;
      check("dual.a", 32'(rsrc), 32'h00AA);
      check("dual.b", 32'(rdst), 32'h5500);
      cycle("dual_rd");

      // Collision on R4
      idle();
      we0 = 1'b1; wa0 = 3'd4; wd0 = 16'h1111;
      we1 = 1'b1; wa1 = 3'd4; wd1 = 16'h2222;
      src = 3'd4;
      #3 check("coll.same", 32'(rsrc), BYP ? 32'h2222 : 32'h0000);
      cycle("coll_w");
      idle(); src = 3'd4;
      #3 check("coll.after", 32'(rsrc), 32'h2222);
      cycle("coll_rd");

      // Bypass on R1
      idle(); we0 = 1'b1; wa0 = 3'd1; wd0 = 16'h0001;
      cycle("byp_pre");
      idle(); we0 = 1'b1; wa0 = 3'd1; wd0 = 16'hBEEF; src = 3'd1;
      #3 check("byp.same", 32'(rsrc), BYP ? 32'hBEEF : 32'h0001);
      cycle("byp_w");
      idle(); src = 3'd1;
      #3 check("byp.next", 32'(rsrc), 32'hBEEF);
      cycle("byp_rd");

      // Scoreboard on R6
      idle(); rsv_en = 1'b1; rsv_addr = 3'd6; src = 3'd6;
      #3 check("sb.rsv_cycle", 32'(src_busy), 32'h0);
      cycle("sb_rsv");
      idle(); src = 3'd6;
      #3 check("sb.set", 32'(src_busy), 32'h1);
      cycle("sb_hold");
      idle(); we0 = 1'b1; wa0 = 3'd6; wd0 = 16'h6666; src = 3'd6;
      #3 check("sb.wb_cycle", 32'(src_busy), BYP ? 32'h0 : 32'h1);
      cycle("sb_wb");
      idle(); src = 3'd6;
      #3 check("sb.cleared", 32'(src_busy), 32'h0);
      cycle("sb_clr");

      // Set and clear together on R7
      idle(); rsv_en = 1'b1; rsv_addr = 3'd7;
      cycle("sc_rsv");
      idle(); rsv_en = 1'b1; rsv_addr = 3'd7; we0 = 1'b1; wa0 = 3'd7; wd0 = 16'h7777;
      cycle("sc_both");
      idle(); src = 3'd7;
      #3;
      check("sc.busy", 32'(src_busy), 32'h1);
      check("sc.data", 32'(rsrc), 32'h7777);
      cycle("sc_rd");

      // Mid-cycle asynchronous reset
      idle(); we0 = 1'b1; wa0 = 3'd3; wd0 = 16'h1234; rsv_en = 1'b1; rsv_addr = 3'd3;
      cycle("rst_pre");
      idle(); src = 3'd3;
      #2 rst = 1'b0;
      #1;
      check("rst.rsrc", 32'(rsrc), 32'h0);
      check("rst.any", 32'(any_busy), 32'h0);
      check("rst.src_busy", 32'(src_busy), 32'h0);
      model_reset();
      we1 = 1'b1; wa1 = 3'd3; wd1 = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd2;
      #1 check("rst.bypass_gated", 32'(rsrc), 32'h0);
      @(posedge clk);
      #1 idle(); src = 3'd3;
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      idle(); src = 3'd3;
      #3 check("rst.after", 32'(rsrc), 32'h0000);
      cycle("rst_after");

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         we0 = 1'($urandom); wa0 = N'($urandom); wd0 = W'($urandom);
         we1 = 1'($urandom); wa1 = N'($urandom); wd1 = W'($urandom);
         rsv_en = ($urandom_range(0, 3) == 0);
         rsv_addr = N'($urandom);
         src = N'($urandom); dst = N'($urandom);
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
